// File: rtl/jump_exec_unit_pkg.sv
// Shared encodings and types for the JAL/JALR execute stage.
package jump_exec_unit_pkg;

  localparam logic [1:0] JMP_NOP = 2'b00;
  localparam logic [1:0] JAL     = 2'b01;
  localparam logic [1:0] JALR    = 2'b10;

  localparam int IALIGN_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REDIR = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/jump_target_calc.sv
// Combinational jump target, link value and misalignment flag.
module jump_target_calc
  import jump_exec_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int IALIGN = IALIGN_DEFAULT
) (
  input  logic [1:0]      i_jump_control,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [20:0]     i_imm,
  output logic            o_is_jump,
  output logic [XLEN-1:0] o_target,
  output logic [XLEN-1:0] o_link,
  output logic            o_misalign
);

  logic [XLEN-1:0] w_jal_off;
  logic [XLEN-1:0] w_jalr_off;
  logic [XLEN-1:0] w_jalr_sum;

  assign w_jal_off  = {{(XLEN-21){i_imm[20]}}, i_imm};
  assign w_jalr_off = {{(XLEN-12){i_imm[11]}}, i_imm[11:0]};
  assign w_jalr_sum = i_rs1_data + w_jalr_off;
  assign o_link     = i_pc + XLEN'(4);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_is_jump = 1'b0;
    o_target  = '0;
    case (i_jump_control)
      JAL: begin
        o_is_jump = 1'b1;
        o_target  = i_pc + w_jal_off;
      end
      JALR: begin
        o_is_jump = 1'b1;
        o_target  = {w_jalr_sum[XLEN-1:1], 1'b0};
      end
      default: ;
    endcase
  end

  // With 16-bit alignment only bit 0 matters, and JALR already forces it low.
  assign o_misalign = (IALIGN == 32) ? o_target[1] : o_target[0];

endmodule

// File: rtl/jump_exec_unit.sv
// JAL/JALR execute stage: link writeback, fetch redirect handshake, drain window, misalign exception.
module jump_exec_unit
  import jump_exec_unit_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int IALIGN       = IALIGN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [XLEN-1:0] i_pc,
  input  logic [1:0]      i_jump_control,
  input  logic [4:0]      i_rd,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [20:0]     i_imm,
  output logic            o_redirect_valid,
  input  logic            i_redirect_ready,
  output logic [XLEN-1:0] o_redirect_target,
  output logic            o_flush,
  output logic            o_wb_valid,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_data,
  output logic            o_misalign_exc,
  output logic [XLEN-1:0] o_exc_pc,
  output logic [XLEN-1:0] o_exc_tval
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t          r_state;
  logic [CW-1:0]   r_drain_cnt;
  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_target;
  logic            r_flush;
  logic            r_wb_valid;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_data;
  logic            r_misalign_exc;
  logic [XLEN-1:0] r_exc_pc;
  logic [XLEN-1:0] r_exc_tval;

  logic            w_is_jump;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_link;
  logic            w_misalign;

  jump_target_calc #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_calc (
    .i_jump_control (i_jump_control),
    .i_pc           (i_pc),
    .i_rs1_data     (i_rs1_data),
    .i_imm          (i_imm),
    .o_is_jump      (w_is_jump),
    .o_target       (w_target),
    .o_link         (w_link),
    .o_misalign     (w_misalign)
  );

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state           <= IDLE;
      r_drain_cnt       <= '0;
      r_redirect_valid  <= 1'b0;
      r_redirect_target <= '0;
      r_flush           <= 1'b0;
      r_wb_valid        <= 1'b0;
      r_wb_rd           <= '0;
      r_wb_data         <= '0;
      r_misalign_exc    <= 1'b0;
      r_exc_pc          <= '0;
      r_exc_tval        <= '0;
    end else begin
      // Pulse outputs live for exactly one cycle unless re-armed below.
      r_flush        <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_misalign_exc <= 1'b0;
      r_exc_pc       <= '0;
      r_exc_tval     <= '0;
      case (r_state)
        IDLE: begin
          if (i_in_valid && w_is_jump) begin
            if (w_misalign) begin
              r_misalign_exc <= 1'b1;
              r_exc_pc       <= i_pc;
              r_exc_tval     <= w_target;
            end else begin
              r_redirect_valid  <= 1'b1;
              r_redirect_target <= w_target;
              r_flush           <= 1'b1;
              r_wb_valid        <= (i_rd != 5'd0);
              r_wb_rd           <= i_rd;
              r_wb_data         <= w_link;
              r_state           <= REDIR;
            end
          end
        end
        REDIR: begin
          if (i_redirect_ready) begin
            r_redirect_valid <= 1'b0;
            if (FLUSH_CYCLES == 0) begin
              r_state <= IDLE;
            end else begin
              r_drain_cnt <= CW'(FLUSH_CYCLES - 1);
              r_state     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (r_drain_cnt == '0) r_state <= IDLE;
          else                   r_drain_cnt <= r_drain_cnt - 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_in_ready        = (r_state == IDLE);
  assign o_redirect_valid  = r_redirect_valid;
  assign o_redirect_target = r_redirect_target;
  assign o_flush           = r_flush;
  assign o_wb_valid        = r_wb_valid;
  assign o_wb_rd           = r_wb_rd;
  assign o_wb_data         = r_wb_data;
  assign o_misalign_exc    = r_misalign_exc;
  assign o_exc_pc          = r_exc_pc;
  assign o_exc_tval        = r_exc_tval;

endmodule
